rfm3: RTL
=========

// Module: rfm3
// PURPOSE
//  Parametrised successor of the CPU2 register file: 2**AW registers of WIDTH bits, four read ports (a,b,d,t).
//  Dedicated PC and LR registers; write-back and ra-change write paths.
//  Adds optional same-cycle write-back bypass and a per-register busy scoreboard for the pipelined core.
//  Sits between decode (read addresses, issue) and write-back (wb_data) and drives the fetch PC.
// PARAMETERS
//  WIDTH     32  data width of every register
//  AW        4   register address width; NREGS = 2**AW (AW >= 2)
//  PC_RESET  0   PC value loaded on reset
//  BYPASS    1   1: read ports forward same-cycle wb_data; 0: read ports show stored values only
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high reset
//  ra,rb,rd,rt   in   AW      read addresses, ports a/b/d/t
//  use           in   4       read-port-in-use mask {t,d,b,a}, scoreboard check only
//  fn_inc_pc     in   1       PC <= PC+1
//  fn_link       in   1       LR <= current PC
//  fn_ra_change  in   1       reg[ra] <= ra_changed (post-inc/dec addressing)
//  ra_changed    in   WIDTH   data for fn_ra_change
//  fn_wb         in   1       reg[rw] <= wb_data; clears busy[rw]
//  rw            in   AW      write-back address
//  wb_data       in   WIDTH   write-back data
//  issue         in   1       instruction with destination rw_issue issued
//  rw_issue      in   AW      destination to mark busy
//  da,db,dd,dt   out  WIDTH   read data
//  pc            out  WIDTH   reg[NREGS-1]
//  stall         out  1       an in-use read port hits a busy, non-bypassed register
// BEHAVIOUR
//  - Register map: PC = reg[NREGS-1], LR = reg[NREGS-2].
//  - Reset: all registers 0 except PC = PC_RESET; all busy bits 0; stall = 0. Takes effect immediately, any cycle.
//  - Writes land at the clock edge; reads are combinational.
//  - Per-register write priority, highest first:
//      fn_wb(rw==i) > fn_ra_change(ra==i) > fn_link (LR only) > fn_inc_pc (PC only).
//  - Write-back to PC with fn_inc_pc set: wb_data wins (taken jump).
//  - fn_link copies the PC value from before the edge, not PC+1.
//  - PC+1 wraps modulo 2**WIDTH.
//  - Read mux: port x returns reg[rx].
//    If BYPASS=1 and fn_wb and rw==rx, port x returns wb_data instead.
//  - Bypass applies to the PC too; the pc output itself is never bypassed.
//  - Scoreboard, per register i, next value:
//      busy[i] <= (issue & rw_issue==i) | (busy[i] & ~(fn_wb & rw==i)).
//    Set and clear in the same cycle: set wins, because the new producer stays pending.
//  - stall = OR over ports x with use[x] of (busy[rx] & ~(BYPASS & fn_wb & rw==rx)). Combinational.
//  - Busy tracking covers every register, PC included; ra-change, link and inc_pc do not touch busy bits.
//  - Simultaneous ra_change and wb to the same register: wb data stored (priority above), busy cleared.
// STRUCTURE
//  - Shared package rfm_pkg: function for NREGS from AW, PC_IDX/LR_IDX index functions, port order constants A=0,B=1,D=2,T=3.
//  - One sub-module: rfm3_rdport (AW, WIDTH, BYPASS).
//    Inputs: register array flattened, rx, use bit, busy vector, fn_wb, rw, wb_data. Outputs: data and stall term.
//    Instantiated four times.
//  - Register storage and scoreboard as generate loops in rfm3; no per-register instances.
// TESTING
//  1. Reset mid-run with PC=0x40 and busy[3]=1 -> all reads 0, pc=PC_RESET, stall=0, same cycle as reset asserts.
//  2. fn_inc_pc for 3 cycles from PC=0xFFFFFFFE (WIDTH=32) -> pc 0xFFFFFFFF, 0, 1.
//  3. fn_link & fn_inc_pc at PC=0x10 -> LR=0x10, PC=0x11.
//     Same cycle adding fn_wb rw=LR with 0xAA -> LR=0xAA.
//  4. fn_wb rw=PC with 0x200 & fn_inc_pc at PC=0x10 -> PC=0x200.
//     fn_wb and fn_ra_change both to r5 -> r5=wb_data.
//  5. BYPASS=1: fn_wb rw=2, wb_data=0x55, ra=rb=2 -> da=db=0x55 before the edge.
//     BYPASS=0, same stimulus -> old r2 value.
//  6. issue rw_issue=7; next cycle ra=7, use=0001 -> stall=1.
//     Same stimulus with use=0000 -> stall=0.
//     fn_wb rw=7 -> stall=0 (BYPASS=1) in that cycle, busy[7] clear after the edge.
//     issue and fn_wb both on r7 in one cycle -> busy[7] stays 1.
//  AW=3 and AW=5 builds rerun 2-6 with PC/LR at NREGS-1/NREGS-2.

Source files
------------

// File: rtl/rfm_pkg.sv
// Shared definitions for the rfm3 register file: register count, PC/LR indices, read-port order.
package rfm_pkg;

    localparam int unsigned PORT_A = 0;
    localparam int unsigned PORT_B = 1;
    localparam int unsigned PORT_D = 2;
    localparam int unsigned PORT_T = 3;

    function automatic int unsigned nregs(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic int unsigned pc_idx(input int unsigned aw);
        return nregs(aw) - 1;
    endfunction

    function automatic int unsigned lr_idx(input int unsigned aw);
        return nregs(aw) - 2;
    endfunction

endpackage

// File: rtl/rfm3_rdport.sv
// One combinational read port: register select, optional write-back forwarding, stall term.
module rfm3_rdport
    import rfm_pkg::*;
#(
    parameter int unsigned AW     = 4,
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [nregs(AW)*WIDTH-1:0] regs_flat,
    input  logic [AW-1:0]              rx,
    input  logic                       use_bit,
    input  logic [nregs(AW)-1:0]       busy,
    input  logic                       fn_wb,
    input  logic [AW-1:0]              rw,
    input  logic [WIDTH-1:0]           wb_data,
    output logic [WIDTH-1:0]           data,
    output logic                       stall_term
);

    logic hit;

    // A forwarded write-back both supplies the data and resolves the hazard.
    assign hit        = BYPASS && fn_wb && (rw == rx);
    assign data       = hit ? wb_data : regs_flat[rx*WIDTH +: WIDTH];
    assign stall_term = use_bit && busy[rx] && !hit;

endmodule

// File: rtl/rfm3.sv
// Pipelined-core register file: 2**AW registers, four read ports, PC/LR paths, busy scoreboard.
module rfm3
    import rfm_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      AW       = 4,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter bit               BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    rd,
    input  logic [AW-1:0]    rt,
    input  logic [3:0]       use_mask,
    input  logic             fn_inc_pc,
    input  logic             fn_link,
    input  logic             fn_ra_change,
    input  logic [WIDTH-1:0] ra_changed,
    input  logic             fn_wb,
    input  logic [AW-1:0]    rw,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             issue,
    input  logic [AW-1:0]    rw_issue,
    output logic [WIDTH-1:0] da,
    output logic [WIDTH-1:0] db,
    output logic [WIDTH-1:0] dd,
    output logic [WIDTH-1:0] dt,
    output logic [WIDTH-1:0] pc,
    output logic             stall
);

    localparam int unsigned NREGS = nregs(AW);
    localparam int unsigned PC    = pc_idx(AW);
    localparam int unsigned LR    = lr_idx(AW);

    logic [NREGS*WIDTH-1:0] regs_flat;
    logic [NREGS-1:0]       busy;
    logic [WIDTH-1:0]       pc_cur;
    logic [3:0]             stall_term;

    assign pc_cur = regs_flat[PC*WIDTH +: WIDTH];

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(i);
        logic [WIDTH-1:0] q;
        logic             busy_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q      <= (i == PC) ? PC_RESET : '0;
                busy_q <= 1'b0;
            end else begin
                if (fn_wb && rw == IDX) begin
                    q <= wb_data;
                end else if (fn_ra_change && ra == IDX) begin
                    q <= ra_changed;
                end else if (i == LR && fn_link) begin
                    q <= pc_cur;
                end else if (i == PC && fn_inc_pc) begin
                    q <= pc_cur + WIDTH'(1);
                end
                // A new issue keeps the register pending even if an older write-back retires.
                busy_q <= (issue && rw_issue == IDX) || (busy_q && !(fn_wb && rw == IDX));
            end
        end

        assign regs_flat[i*WIDTH +: WIDTH] = q;
        assign busy[i]                     = busy_q;
    end

    rfm3_rdport #(.AW(AW), .WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_a (
        .regs_flat (regs_flat),
        .rx        (ra),
        .use_bit   (use_mask[PORT_A]),
        .busy      (busy),
        .fn_wb     (fn_wb),
        .rw        (rw),
        .wb_data   (wb_data),
        .data      (da),
        .stall_term(stall_term[PORT_A])
    );

    rfm3_rdport #(.AW(AW), .WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_b (
        .regs_flat (regs_flat),
        .rx        (rb),
        .use_bit   (use_mask[PORT_B]),
        .busy      (busy),
        .fn_wb     (fn_wb),
        .rw        (rw),
        .wb_data   (wb_data),
        .data      (db),
        .stall_term(stall_term[PORT_B])
    );

    rfm3_rdport #(.AW(AW), .WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_d (
        .regs_flat (regs_flat),
        .rx        (rd),
        .use_bit   (use_mask[PORT_D]),
        .busy      (busy),
        .fn_wb     (fn_wb),
        .rw        (rw),
        .wb_data   (wb_data),
        .data      (dd),
        .stall_term(stall_term[PORT_D])
    );

    rfm3_rdport #(.AW(AW), .WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_t (
        .regs_flat (regs_flat),
        .rx        (rt),
        .use_bit   (use_mask[PORT_T]),
        .busy      (busy),
        .fn_wb     (fn_wb),
        .rw        (rw),
        .wb_data   (wb_data),
        .data      (dt),
        .stall_term(stall_term[PORT_T])
    );

    assign pc    = pc_cur;
    assign stall = |stall_term;

endmodule
